crc_frame_rx: RTL and testbench
===============================

Name: crc_frame_rx

Overview:
- Receive-side counterpart of the TX CRC framer on the RS-485 link.
- Accepts the 5-byte frame from the UART RX byte interface, most significant byte first, as one byte-valid stream: bytes 0-2 are 24-bit payload, bytes 3-4 are CRC-16.
- Computes a running CRC-16 over all 5 bytes and checks the frame: polynomial 0x1021, init 0x0000, MSB-first, no reflection, no final XOR.
- Delivers the payload with a one-cycle good or error strobe to the command decoder.

Parameters:
- DATA_BYTES, 3, payload bytes per frame.
- CRC_BYTES, 2, CRC bytes per frame. Fixed for CRC-16; any other value is illegal.
- TIMEOUT_CYCLES, 50000, inter-byte gap limit in clk cycles. Used only with CRC_RX_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- rx_byte  input  8  received byte from the UART RX.
- rx_valid  input  1  one-cycle strobe qualifying rx_byte.
- data_out  output  24  payload of the last completed frame.
- frame_ok  output  1  one-cycle pulse: frame complete, CRC good.
- crc_err  output  1  one-cycle pulse: frame complete, CRC bad.
- timeout_err  output  1  one-cycle pulse: partial frame aborted (tied 0 without CRC_RX_TIMEOUT_EN).
- busy  output  1  high while a partial frame is held (byte count 1..4).

Behaviour:
- Reset (rst=1 at a clk edge):
  - data_out=0, frame_ok=0, crc_err=0, timeout_err=0, busy=0.
  - byte count=0, crc register=0x0000, payload shift register=0.
  - Reset overrides everything, including an rx_valid in the same cycle and any partial frame.
- FSM, state held as byte count bcnt (0..4):
  - IDLE (bcnt=0), RECV (bcnt=1..4). busy = (bcnt!=0).
- On each rx_valid:
  - crc_next = CRC of rx_byte folded into crc register, 8 bit-steps MSB-first in one cycle (combinational loop). Per step: fb = crc[15]^bit; shift left; XOR fb into bits 0, 5 and 12.
  - bcnt<4: crc<=crc_next; bytes 0-2 also shift into the payload register; bcnt<=bcnt+1.
  - bcnt==4 (last byte):
    - if crc_next==0x0000: frame_ok<=1, data_out<=payload.
    - else: crc_err<=1, data_out unchanged.
    - crc<=0, payload<=0, bcnt<=0.
- Latency: frame_ok/crc_err asserts the cycle after the 5th rx_valid edge.
- Back-to-back frames:
  - rx_valid the cycle right after the 5th byte is byte 0 of the next frame.
  - No dead cycle.
- Pulse rules:
  - frame_ok and crc_err are mutually exclusive and never high two consecutive cycles from one frame.
  - Both default to 0 every cycle.
- No backpressure. Every rx_valid byte is consumed.
- Width: CRC arithmetic is 16-bit modulo-2; the payload register is exactly 24 bits.

Optional Feature:
- Macro CRC_RX_TIMEOUT_EN.
- Defined:
  - 16-bit gap counter, cleared on every rx_valid and whenever bcnt==0.
  - Increments each cycle while bcnt!=0.
  - On reaching TIMEOUT_CYCLES-1 without rx_valid: timeout_err pulses one cycle; bcnt, crc and payload clear; data_out unchanged.
  - An rx_valid in that same cycle wins: it is processed normally and no timeout fires.
- Not defined:
  - No counter; timeout_err is constant 0.
  - A partial frame waits indefinitely for its remaining bytes.

Decomposition:
- Shared package crc_pkg:
  - CRC_POLY=16'h1021, CRC_INIT=16'h0000, FRAME_BYTES=5.
  - Function crc16_byte(crc, byte) returning the next CRC. Also used by the TX framer.
- Natural sub-module: crc16_byte_step, a combinational 8-bit fold wrapping the package function.
- FSM, payload register and timeout stay in crc_frame_rx.

Test Plan:
- Reset then bytes 00 00 01 10 21 on consecutive cycles -> frame_ok=1 one cycle after the 5th byte, data_out=0x000001, crc_err=0.
- Bytes 00 00 02 20 42 immediately followed by 00 00 00 00 00 -> two frame_ok pulses 5 cycles apart; data_out 0x000002 then 0x000000.
- Bytes 00 00 01 10 20 (corrupt CRC) -> crc_err=1, frame_ok=0, data_out keeps its previous value. The next good frame passes.
- Assert rst after 3 bytes of a frame, then send 00 00 01 10 21 -> no strobe from the aborted frame; the new frame gives frame_ok, data_out=0x000001, busy=0 right after reset.
- CRC_RX_TIMEOUT_EN, TIMEOUT_CYCLES=16: send 2 bytes then idle 20 cycles -> timeout_err pulses exactly once, busy falls. A following full frame is received correctly.
- Bytes separated by random 0-10 idle cycles (no timeout) -> the same results as back-to-back delivery.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared CRC-16 definitions for the RS-485 framers (TX and RX).
// CRC-16: poly 0x1021, init 0x0000, MSB-first, no reflection, no final XOR.
// Contents: CRC constants, frame length, receiver phase enum, crc16_byte() fold function.
package crc_pkg;

  localparam logic [15:0] CRC_POLY    = 16'h1021;
  localparam logic [15:0] CRC_INIT    = 16'h0000;
  localparam int unsigned FRAME_BYTES = 5;

  typedef enum logic {StIdle, StRecv} rx_phase_e;

  // Fold one byte into the running CRC, MSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_frame_rx_if.sv
// Byte-stream and result bundle of the CRC frame receiver.
// master: UART/decoder side (drives rx_byte/rx_valid, observes results).
// slave : crc_frame_rx (consumes bytes, drives data_out and status strobes).
interface crc_frame_rx_if;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [23:0] data_out;
  logic        frame_ok;
  logic        crc_err;
  logic        timeout_err;
  logic        busy;

  modport master (
    output rx_byte, rx_valid,
    input  data_out, frame_ok, crc_err, timeout_err, busy
  );

  modport slave (
    input  rx_byte, rx_valid,
    output data_out, frame_ok, crc_err, timeout_err, busy
  );
endinterface

// File: rtl/crc16_byte_step.sv
// Combinational CRC-16 fold of one byte into a running CRC.
// Ports: crc_i (current CRC), data_i (byte), crc_o (CRC after the byte).
module crc16_byte_step
  import crc_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  assign crc_o = crc16_byte(crc_i, data_i);

endmodule

// File: rtl/crc_frame_rx.sv
// CRC-16 frame receiver: 3 payload bytes + 2 CRC bytes, MSB first.
// Checks the running CRC over all 5 bytes (residue 0 means good) and
// strobes frame_ok or crc_err one cycle after the last byte.
// Ports: clk, rst (sync, active-high), bus (crc_frame_rx_if.slave):
//   rx_byte/rx_valid in; data_out, frame_ok, crc_err, timeout_err, busy out.
// Optional: define CRC_RX_TIMEOUT_EN to abort partial frames after an
// inter-byte gap of TIMEOUT_CYCLES; otherwise timeout_err is tied low.
module crc_frame_rx
  import crc_pkg::*;
#(
  parameter int unsigned DATA_BYTES     = 3,
  parameter int unsigned CRC_BYTES      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           rst,
  crc_frame_rx_if.slave  bus
);

  if (CRC_BYTES != 2 || DATA_BYTES + CRC_BYTES != FRAME_BYTES) begin : g_bad_frame
    $error("crc_frame_rx: frame must be 3 data + 2 CRC bytes");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("crc_frame_rx: TIMEOUT_CYCLES out of 16-bit counter range");
  end

  localparam logic [2:0] LastIdx = 3'(FRAME_BYTES - 1);
  localparam logic [2:0] DataIdx = 3'(DATA_BYTES);

  logic [2:0]  bcnt_q, bcnt_d;
  logic [15:0] crc_q, crc_d, crc_next;
  logic [23:0] payload_q, payload_d;
  logic [23:0] data_out_q, data_out_d;
  logic        frame_ok_q, frame_ok_d;
  logic        crc_err_q, crc_err_d;
  logic        timeout_q, timeout_d;
  rx_phase_e   phase;

  crc16_byte_step u_step (
    .crc_i  (crc_q),
    .data_i (bus.rx_byte),
    .crc_o  (crc_next)
  );

  assign phase = (bcnt_q == 3'd0) ? StIdle : StRecv;

`ifdef CRC_RX_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] gap_q, gap_d;
  logic        gap_expired;

  assign gap_expired = (phase == StRecv) && (gap_q == TimeoutLast);
`endif

  always_comb begin
    bcnt_d     = bcnt_q;
    crc_d      = crc_q;
    payload_d  = payload_q;
    data_out_d = data_out_q;
    frame_ok_d = 1'b0;
    crc_err_d  = 1'b0;
    timeout_d  = 1'b0;
`ifdef CRC_RX_TIMEOUT_EN
    gap_d      = (bus.rx_valid || phase == StIdle) ? 16'd0 : gap_q + 16'd1;
`endif
    if (bus.rx_valid) begin
      if (bcnt_q == LastIdx) begin
        // Residue of a good frame with its CRC appended is zero.
        if (crc_next == 16'h0000) begin
          frame_ok_d = 1'b1;
          data_out_d = payload_q;
        end else begin
          crc_err_d = 1'b1;
        end
        crc_d     = CRC_INIT;
        payload_d = '0;
        bcnt_d    = 3'd0;
      end else begin
        crc_d = crc_next;
        if (bcnt_q < DataIdx) payload_d = {payload_q[15:0], bus.rx_byte};
        bcnt_d = bcnt_q + 3'd1;
      end
    end
`ifdef CRC_RX_TIMEOUT_EN
    else if (gap_expired) begin
      timeout_d = 1'b1;
      crc_d     = CRC_INIT;
      payload_d = '0;
      bcnt_d    = 3'd0;
      gap_d     = 16'd0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q     <= 3'd0;
      crc_q      <= CRC_INIT;
      payload_q  <= '0;
      data_out_q <= '0;
      frame_ok_q <= 1'b0;
      crc_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      bcnt_q     <= bcnt_d;
      crc_q      <= crc_d;
      payload_q  <= payload_d;
      data_out_q <= data_out_d;
      frame_ok_q <= frame_ok_d;
      crc_err_q  <= crc_err_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef CRC_RX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) gap_q <= 16'd0;
    else     gap_q <= gap_d;
  end
  assign bus.timeout_err = timeout_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.data_out = data_out_q;
  assign bus.frame_ok = frame_ok_q;
  assign bus.crc_err  = crc_err_q;
  assign bus.busy     = (phase == StRecv);

endmodule

// File: tb/tb_crc_frame_rx.sv
// Directed bench for crc_frame_rx. Define CRC_RX_TIMEOUT_EN to also cover
// the inter-byte timeout with TIMEOUT_CYCLES=16.
module tb_crc_frame_rx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crc_frame_rx_if bus ();

`ifdef CRC_RX_TIMEOUT_EN
  crc_frame_rx #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  crc_frame_rx dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Strobe monitor, sampled 1 ns after each rising edge.
  int          cyc = 0;
  int          ok_cyc[$];
  logic [23:0] ok_dat[$];
  int          err_cnt = 0;
  int          to_cnt = 0;
  int          both_cnt = 0;
  int          dbl_cnt = 0;
  logic        prev_strobe = 1'b0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (bus.frame_ok === 1'b1) begin
      ok_cyc.push_back(cyc);
      ok_dat.push_back(bus.data_out);
    end
    if (bus.crc_err === 1'b1) err_cnt++;
    if (bus.timeout_err === 1'b1) to_cnt++;
    if (bus.frame_ok === 1'b1 && bus.crc_err === 1'b1) both_cnt++;
    if (prev_strobe && (bus.frame_ok === 1'b1 || bus.crc_err === 1'b1)) dbl_cnt++;
    prev_strobe = (bus.frame_ok === 1'b1) || (bus.crc_err === 1'b1);
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int last_cyc;

  // Send the n most significant bytes of f, each preceded by 0..maxgap idle cycles.
  task automatic send(input logic [39:0] f, input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (g) begin
        @(negedge clk);
        bus.rx_valid = 1'b0;
      end
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_byte  = f[39 - 8*i -: 8];
      last_cyc     = cyc + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
  endtask

  int base_ok;
  int base_err;

  initial begin
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_data_out", 40'(bus.data_out), 40'h0);
    check("rst_frame_ok", 40'(bus.frame_ok), 40'h0);
    check("rst_crc_err", 40'(bus.crc_err), 40'h0);
    check("rst_timeout", 40'(bus.timeout_err), 40'h0);
    check("rst_busy", 40'(bus.busy), 40'h0);

    // Good frame, back to back
    send(40'h00_00_01_10_21, 5, 0);
    idle(1);
    check("f1_busy_after", 40'(bus.busy), 40'h0);
    idle(1);
    check("f1_ok_count", 40'(ok_cyc.size()), 40'd1);
    check("f1_latency", 40'(ok_cyc[0]), 40'(last_cyc));
    check("f1_data", 40'(ok_dat[0]), 40'h000001);
    check("f1_err_count", 40'(err_cnt), 40'd0);
    check("f1_data_hold", 40'(bus.data_out), 40'h000001);

    // Two frames with no dead cycle between them
    send(40'h00_00_02_20_42, 5, 0);
    send(40'h00_00_00_00_00, 5, 0);
    idle(3);
    check("f23_ok_count", 40'(ok_cyc.size()), 40'd3);
    check("f23_spacing", 40'(ok_cyc[2] - ok_cyc[1]), 40'd5);
    check("f2_data", 40'(ok_dat[1]), 40'h000002);
    check("f3_data", 40'(ok_dat[2]), 40'h000000);
    check("f23_err_count", 40'(err_cnt), 40'd0);

    // Corrupt CRC, then a good frame
    send(40'h00_00_01_10_20, 5, 0);
    idle(3);
    check("bad_err_count", 40'(err_cnt), 40'd1);
    check("bad_no_ok", 40'(ok_cyc.size()), 40'd3);
    check("bad_data_kept", 40'(bus.data_out), 40'h000000);
    send(40'h00_00_01_10_21, 5, 0);
    idle(2);
    check("after_bad_ok", 40'(ok_cyc.size()), 40'd4);
    check("after_bad_data", 40'(bus.data_out), 40'h000001);

    // Reset mid-frame, with a byte offered in the reset cycle
    send(40'h00_00_02_00_00, 3, 0);
    idle(1);
    check("mid_busy", 40'(bus.busy), 40'h1);
    @(negedge clk);
    rst          = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'h20;
    @(negedge clk);
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    check("rst_mid_busy", 40'(bus.busy), 40'h0);
    check("rst_mid_data", 40'(bus.data_out), 40'h0);
    idle(3);
    check("rst_mid_no_ok", 40'(ok_cyc.size()), 40'd4);
    check("rst_mid_no_err", 40'(err_cnt), 40'd1);
    send(40'h00_00_01_10_21, 5, 0);
    idle(2);
    check("rst_next_ok", 40'(ok_cyc.size()), 40'd5);
    check("rst_next_data", 40'(bus.data_out), 40'h000001);

    // Long gap after two bytes
    send(40'h00_00_00_00_00, 2, 0);
    idle(20);
`ifdef CRC_RX_TIMEOUT_EN
    check("to_count", 40'(to_cnt), 40'd1);
    check("to_busy", 40'(bus.busy), 40'h0);
    check("to_data_kept", 40'(bus.data_out), 40'h000001);
    send(40'h00_00_02_20_42, 5, 0);
    idle(2);
    check("to_next_ok", 40'(ok_cyc.size()), 40'd6);
    check("to_next_data", 40'(bus.data_out), 40'h000002);
`else
    check("wait_no_timeout", 40'(to_cnt), 40'd0);
    check("wait_busy", 40'(bus.busy), 40'h1);
    send(40'h01_10_21_00_00, 3, 0);
    idle(2);
    check("wait_resume_ok", 40'(ok_cyc.size()), 40'd6);
    check("wait_resume_data", 40'(bus.data_out), 40'h000001);
`endif

    // Random gaps between bytes
    base_ok  = ok_cyc.size();
    base_err = err_cnt;
    send(40'h00_00_02_20_42, 5, 10);
    idle(2);
    check("gap_ok_latency", 40'(ok_cyc[base_ok]), 40'(last_cyc));
    check("gap_ok_data", 40'(ok_dat[base_ok]), 40'h000002);
    send(40'h00_00_01_10_20, 5, 10);
    idle(2);
    check("gap_bad_err", 40'(err_cnt - base_err), 40'd1);
    check("gap_bad_data_kept", 40'(bus.data_out), 40'h000002);
    send(40'h00_00_01_10_21, 5, 10);
    idle(2);
    check("gap_good_count", 40'(ok_cyc.size() - base_ok), 40'd2);
    check("gap_good_data", 40'(bus.data_out), 40'h000001);

    // Global strobe rules
    check("strobe_exclusive", 40'(both_cnt), 40'd0);
    check("strobe_single", 40'(dbl_cnt), 40'd0);
`ifndef CRC_RX_TIMEOUT_EN
    check("timeout_tied_low", 40'(to_cnt), 40'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
